seq_event_logger: RTL
=====================

# seq_event_logger

Downstream consumer of the 1010 sequence detector's Moore output `q`. Each detection pulse is stamped with a free-running cycle count and pushed into a small first-word-fall-through FIFO. Software or a later stage drains the FIFO over a valid/ready handshake. The block also keeps a saturating total-event count and a sticky overflow flag.

## Interface
Parameters:
- `TS_W`, 16: timestamp counter width.
- `DEPTH`, 4: FIFO entries; a power of two, ≥2.
- `CNT_W`, 8: total-event counter width.

Ports:
- `clk`, in, 1: single clock; everything is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `det`, in, 1: detection pulse, driven by the detector's `q`.
- `clr`, in, 1: synchronous clear of the FIFO, the counters and `ovf`.
- `ev_ready`, in, 1: consumer accepts the head entry.
- `ev_valid`, out, 1: the FIFO is non-empty and `ev_ts` is valid.
- `ev_ts`, out, TS_W: timestamp of the head entry.
- `ev_cnt`, out, CNT_W: total detected events, saturating.
- `ovf`, out, 1: sticky flag, set when an event was dropped because the FIFO was full.
- `level`, out, $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **Timestamp counter `ts`:**
  - Increments by 1 every cycle.
  - Wraps from 2^TS_W−1 to 0 with no flag.
- **Event qualification:**
  - Without the macro: every cycle with `det`=1 at the clock edge is one event.
  - With the macro: see Configuration.
- **Push:**
  - On an event, the pre-increment `ts` value of that same edge is written at the write pointer.
  - This happens only if the FIFO is not full, or if a pop occurs on the same edge.
- **Pop:**
  - Occurs when `ev_valid`=1 and `ev_ready`=1 at the edge.
  - The read pointer advances.
  - `ev_ts` shows the next entry combinationally from storage.
- **Pointers:**
  - Write and read pointers are $clog2(DEPTH)+1 bits and wrap naturally.
  - Full: MSBs differ and the low bits are equal.
  - Empty: the pointers are equal.
  - `level` = wptr − rptr.
- **Full with event:**
  - With no simultaneous pop: the entry is dropped, `ovf` is set to 1, and `ev_cnt` still increments.
  - With a simultaneous pop: both happen, nothing is dropped, `level` is unchanged.
- **Empty with event:** the push happens; a pop is not possible because `ev_valid`=0.
- **`ev_cnt`:**
  - +1 per qualified event, whether stored or dropped.
  - Holds at 2^CNT_W−1 (saturates).
- **`ovf`:** cleared only by `rst` or `clr`.
- **`clr`:**
  - Has priority over `det` and pop on the same edge.
  - Next cycle: pointers 0, `ts`=0, `ev_cnt`=0, `ovf`=0, edge register 0.
  - An event coincident with `clr` is discarded.
- **`ev_ts` when `ev_valid`=0:** don't-care.
- **FIFO storage:** not reset; only the pointers are reset.

## Timing
- **Reset values (during and immediately after `rst`):**
  - `ev_valid`=0, `ev_cnt`=0, `ovf`=0, `level`=0.
  - Internal `ts`=0 and edge register 0.
- **Reset mid-operation:** `rst` asserted at any time discards all FIFO contents asynchronously. No partial pop or push completes.
- **Latency:**
  - `det` high at edge N → `ev_valid`=1 and `ev_ts`=ts(N) after edge N.
  - This makes `ev_valid` visible in cycle N+1 when the FIFO was empty.
- **Handshake rules:**
  - `ev_valid` must not drop without a pop, `rst` or `clr`.
  - `ev_ts` is stable while `ev_valid`=1 and `ev_ready`=0.
  - `ev_ready` may be high while `ev_valid`=0; this has no effect.
- **Throughput:** one push and one pop per cycle.
- **Status timing:** `level`, `ev_cnt` and `ovf` are registered and update at the same edge as the push or pop.

## Configuration
- **Macro `SEQ_EVLOG_RISE_EDGE_EN`.**
- **Defined:**
  - A registered copy `det_q` of `det` is kept.
  - An event is `det & ~det_q`, so a level held high for K cycles is one event.
  - `det_q` resets to 0, so `det` high in the first cycle after reset counts.
- **Undefined:**
  - `det_q` is absent, and every high cycle is an event.
  - For the single-cycle detector pulse the two builds behave identically.

## Test plan
- **Basic stamp:** reset, hold `ev_ready`=0, pulse `det` at `ts`=5 and `ts`=9 → `level`=2, `ev_cnt`=2, head `ev_ts`=5; raise `ev_ready` → 5 then 9 are popped, then `ev_valid`=0.
- **Overflow:** `ev_ready`=0, 5 pulses with DEPTH=4 → `level`=4, `ev_cnt`=5, `ovf`=1; entries are the first four timestamps.
- **Full with simultaneous push and pop:** FIFO full, `ev_ready`=1 and `det`=1 on the same edge → `level` stays 4, `ovf` stays 0, the newest timestamp is at the tail.
- **Wrap and saturate:**
  - Run with CNT_W=3 and 9 events → `ev_cnt`=7.
  - Run with TS_W=4 until `ts` wraps, event at cycle 17 → `ev_ts`=1.
- **`clr` and `rst` mid-stream:**
  - `clr` coincident with `det` and FIFO level 2 → next cycle `level`=0, `ev_cnt`=0, `ovf`=0, `ev_valid`=0.
  - Async `rst` between edges → outputs 0 immediately.
- **Macro check:** `det` held high for 3 cycles → `ev_cnt`=1 with `SEQ_EVLOG_RISE_EDGE_EN` defined, `ev_cnt`=3 without.

Source files
------------

// File: rtl/seq_event_logger.sv
// seq_event_logger: stamps each detection pulse from the 1010 detector with a
// free-running cycle count and queues it in a first-word-fall-through FIFO that
// a consumer drains over valid/ready. Also keeps a saturating event count and
// a sticky overflow flag.
//
// Build option: define SEQ_EVLOG_RISE_EDGE_EN to count only rising edges of
// det (a level held high is one event). Left undefined, every cycle with det
// high is an event.
module seq_event_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     det,
    input  logic                     clr,
    input  logic                     ev_ready,
    output logic                     ev_valid,
    output logic [TS_W-1:0]          ev_ts,
    output logic [CNT_W-1:0]         ev_cnt,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [TS_W-1:0] ts;
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [TS_W-1:0] mem [DEPTH];

    logic ev;
    logic full;
    logic empty;
    logic pop;
    logic push;

`ifdef SEQ_EVLOG_RISE_EDGE_EN
    logic det_q;

    // Previous-cycle copy of det for rising-edge qualification; cleared by clr
    // so a det held high across a clear counts again afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      det_q <= 1'b0;
        else if (clr) det_q <= 1'b0;
        else          det_q <= det;
    end

    assign ev = det & ~det_q;
`else
    assign ev = det;
`endif

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign ev_valid = ~empty;
    assign pop      = ev_valid & ev_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push     = ev & (~full | pop);
    assign level    = wptr - rptr;
    assign ev_ts    = mem[rptr[AW-1:0]];

    // Free-running timestamp; wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      ts <= '0;
        else if (clr) ts <= '0;
        else          ts <= ts + TS_W'(1);
    end

    // FIFO pointers; clr wins over any push or pop on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
        end
    end

    // Storage is deliberately unreset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (push && !clr && !rst) mem[wptr[AW-1:0]] <= ts;
    end

    // Total events, stored or dropped, saturating at the top value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            ev_cnt <= '0;
        else if (clr)                       ev_cnt <= '0;
        else if (ev && (ev_cnt != CNT_MAX)) ev_cnt <= ev_cnt + CNT_W'(1);
    end

    // Sticky flag for an event lost to a full FIFO with no pop to make room.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     ovf <= 1'b0;
        else if (clr)                ovf <= 1'b0;
        else if (ev && full && !pop) ovf <= 1'b1;
    end

endmodule
